serial_frame_receiver: RTL

- Receive end of the team's serial link: recovers 8-bit characters from the line driven by the transmit path (p2s plus bit/sample counters) at one bit per SAMPLES clocks.
- Synchronises the line, validates start bits, mid-bit samples data LSB-first and checks the stop bit.
- Presents each character in a holding register with a valid/read handshake, plus framing-error and overrun status.

---
 rtl/serial_frame_receiver.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Receive end of the serial link. The line is synchronised, a falling edge
//   is qualified as a start bit by a mid-bit re-sample, DATA_BITS data bits are
//   sampled LSB first at mid-bit, and the stop bit is checked. Good characters
//   land in a holding register with a valid/read handshake. Framing-error and
//   overrun status are also reported.
//
// Ports
//   clk               in   system clock, all logic on posedge
//   reset             in   synchronous, active-low reset
//   serialDataIn      in   asynchronous line, idles high
//   parallelDataIn    out  holding register, last good character
//   characterReceived out  holding register holds an unread character
//   readAck           in   consumer strobe, clears characterReceived and overrun
//   framingError      out  one-cycle pulse when the stop bit is sampled low
//   overrun           out  sticky, an unread character was overwritten
//   busy              out  receiver is inside a frame (not IDLE)
module serial_frame_receiver #(
  parameter int SAMPLES     = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serialDataIn,
  output logic [DATA_BITS-1:0] parallelDataIn,
  output logic                 characterReceived,
  input  logic                 readAck,
  output logic                 framingError,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(SAMPLES);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] MID_CNT  = CW'(SAMPLES / 2 - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_cr;
  logic                   r_fe;
  logic                   r_ovr;
  logic                   r_busy;

  logic w_rx;
  logic w_mid;
  logic w_start_ok;
  logic w_sample;
  logic w_commit;
  logic w_frame_err;

  assign w_rx  = r_sync[SYNC_STAGES-1];
  assign w_mid = (r_cnt == MID_CNT);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_next_state = S_START;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_START: begin
        if (w_mid) begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (w_rx) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_DATA;
          end
        end else begin
          w_next_state = S_START;
        end
      end
      S_DATA: begin
        if (w_mid && (r_idx == LAST_IDX)) begin
          w_next_state = S_STOP;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_STOP: begin
        if (w_mid) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_STOP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    w_start_ok  = 1'b0;
    w_sample    = 1'b0;
    w_commit    = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start_ok = 1'b0;
      end
      S_START: begin
        w_start_ok = w_mid & ~w_rx;
      end
      S_DATA: begin
        w_sample = w_mid;
      end
      S_STOP: begin
        w_commit    = w_mid & w_rx;
        w_frame_err = w_mid & ~w_rx;
      end
      default: begin
        w_start_ok = 1'b0;
      end
    endcase
  end

  // Synchroniser, bit timing, shift register and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync  <= {SYNC_STAGES{1'b1}};
      r_cnt   <= {CW{1'b0}};
      r_idx   <= {IW{1'b0}};
      r_shift <= {DATA_BITS{1'b0}};
      r_data  <= {DATA_BITS{1'b0}};
      r_cr    <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], serialDataIn};

      // The counter free-runs modulo SAMPLES inside a frame, so once the
      // start bit is qualified at count MID_CNT every following hit of
      // MID_CNT is exactly one bit period later.
      if (r_state == S_IDLE) begin
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end

      if (w_start_ok) begin
        r_idx <= {IW{1'b0}};
      end else if (w_sample) begin
        r_idx <= r_idx + {{(IW-1){1'b0}}, 1'b1};
      end else begin
        r_idx <= r_idx;
      end

      if (w_sample) begin
        r_shift[r_idx] <= w_rx;
      end else begin
        r_shift <= r_shift;
      end

      r_fe   <= w_frame_err;
      r_busy <= (w_next_state != S_IDLE);

      // A commit beats a coincident readAck: the fresh character stays valid.
      if (w_commit) begin
        r_data <= r_shift;
        r_cr   <= 1'b1;
      end else if (readAck && r_cr) begin
        r_cr <= 1'b0;
      end else begin
        r_cr <= r_cr;
      end

      if (w_commit && r_cr && !readAck) begin
        r_ovr <= 1'b1;
      end else if (readAck && r_cr) begin
        r_ovr <= 1'b0;
      end else begin
        r_ovr <= r_ovr;
      end
    end
  end

  assign parallelDataIn    = r_data;
  assign characterReceived = r_cr;
  assign framingError      = r_fe;
  assign overrun           = r_ovr;
  assign busy              = r_busy;

endmodule
